// File: rtl/multicycle_ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mc_ctrl_pkg
// Description : Shared types and constants for the RV32I multicycle control
//               unit: state encodings, opcode constants, datapath select
//               encodings, the packed control word and an opcode classifier.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

  // State encodings. These values are visible on the debug state output, so
  // they are fixed and must not be renumbered.
  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_ALU_WB    = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JAL       = 4'd9,
    ST_EXEC_I    = 4'd10,
    ST_TRAP      = 4'd11
  } state_e;

  // RV32I major opcodes handled by this controller.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Register write-back source.
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  // PC input source.
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;

  // ALU operation class.
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  // ALU operand B source.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BIMM = 2'b11;

  // Complete set of datapath controls produced for one state.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] wb_sel;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       illegal_instr;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Maps an opcode seen in DECODE to the first execution state.
  function automatic state_e decode_opcode(input logic [6:0] op);
    state_e nxt;
    case (op)
      OP_LOAD,
      OP_STORE:  nxt = ST_MEM_ADDR;
      OP_RTYPE:  nxt = ST_EXEC_R;
      OP_ITYPE:  nxt = ST_EXEC_I;
      OP_BRANCH: nxt = ST_BRANCH;
      OP_JAL:    nxt = ST_JAL;
      default:   nxt = ST_TRAP;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Interface   : multicycle_ctrl_fsm_if
// Description : Bundle between the multicycle controller and the datapath.
// Ports       : opcode, mem_ready           - datapath/memory -> controller
//               pc_write .. illegal_instr  - controller -> datapath
//               state                      - controller debug output
//               modport master = controller side, slave = datapath side
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_fsm_if #(
  parameter int OPCODE_W = 7,
  parameter int STATE_W  = 4
);

  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic [1:0]          wb_sel;
  logic [1:0]          pc_source;
  logic [1:0]          alu_op;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic                reg_write;
  logic                illegal_instr;
  logic [STATE_W-1:0]  state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           wb_sel, pc_source, alu_op, alu_src_a, alu_src_b, reg_write,
           illegal_instr, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           wb_sel, pc_source, alu_op, alu_src_a, alu_src_b, reg_write,
           illegal_instr, state
  );

endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_out_dec.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_out_dec
// Description : Purely combinational state -> control-word decoder for the
//               multicycle controller. Produces the ungated Moore outputs;
//               reset forcing and mem_ready gating are applied by the caller.
// Ports       : state (in, STATE_W) - current state register
//               ctrl  (out, ctrl_t) - decoded control word
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_out_dec
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  output ctrl_t              ctrl
);

  logic [3:0] w_st_lo;
  logic       w_st_legal;

  assign w_st_lo = state[3:0];

  // Any set bit above the 4-bit encoding space marks an unused encoding.
  generate
    if (STATE_W > 4) begin : g_hi_bits
      assign w_st_legal = ~|state[STATE_W-1:4];
    end else begin : g_no_hi_bits
      assign w_st_legal = 1'b1;
    end
  endgenerate

  always_comb begin
    ctrl = CTRL_IDLE;
    if (w_st_legal) begin
      case (w_st_lo)
        ST_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALU_ADD;
          ctrl.pc_source = PCS_ALU;
          // Qualified by mem_ready in the top.
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
        end
        ST_DECODE: begin
          ctrl.alu_src_b = SRCB_BIMM;
        end
        ST_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
        end
        ST_MEM_READ: begin
          ctrl.mem_read = 1'b1;
          ctrl.iord     = 1'b1;
        end
        ST_MEM_WB: begin
          ctrl.reg_write = 1'b1;
          ctrl.wb_sel    = WB_MDR;
        end
        ST_MEM_WRITE: begin
          ctrl.mem_write = 1'b1;
          ctrl.iord      = 1'b1;
        end
        ST_EXEC_R: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_RS2;
          ctrl.alu_op    = ALU_RTYPE;
        end
        ST_ALU_WB: begin
          ctrl.reg_write = 1'b1;
          ctrl.wb_sel    = WB_ALUOUT;
        end
        ST_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_RS2;
          ctrl.alu_op        = ALU_BR;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCS_ALUOUT;
        end
        ST_JAL: begin
          // PC was already advanced to PC+4 in FETCH, so it is the link value.
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCS_ALUOUT;
          ctrl.reg_write = 1'b1;
          ctrl.wb_sel    = WB_PC;
        end
        ST_EXEC_I: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALU_ITYPE;
        end
        ST_TRAP: begin
          ctrl.illegal_instr = 1'b1;
        end
        default: begin
          ctrl = CTRL_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_fsm
// Description : Registered Moore control FSM for the RV32I multicycle
//               datapath. Owns the state register, next-state logic and the
//               reset / mem_ready output gating; the per-state control word
//               comes from mc_ctrl_out_dec.
// Ports       : clk  (in)  - clock, rising edge
//               rst  (in)  - synchronous active-high reset
//               bus  (multicycle_ctrl_fsm_if.master) - opcode, mem_ready in;
//                     datapath enables/selects, illegal_instr, state out
// Config      : MC_CTRL_WAIT_EN - when defined, FETCH / MEM_READ / MEM_WRITE
//               wait for mem_ready; otherwise mem_ready is ignored and each
//               memory state lasts one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int STATE_W  = 4   // must be >= 4
) (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_ctrl_fsm_if.master       bus
);

  localparam logic [STATE_W-1:0] S_FETCH     = STATE_W'(ST_FETCH);
  localparam logic [STATE_W-1:0] S_DECODE    = STATE_W'(ST_DECODE);
  localparam logic [STATE_W-1:0] S_MEM_ADDR  = STATE_W'(ST_MEM_ADDR);
  localparam logic [STATE_W-1:0] S_MEM_READ  = STATE_W'(ST_MEM_READ);
  localparam logic [STATE_W-1:0] S_MEM_WB    = STATE_W'(ST_MEM_WB);
  localparam logic [STATE_W-1:0] S_MEM_WRITE = STATE_W'(ST_MEM_WRITE);
  localparam logic [STATE_W-1:0] S_EXEC_R    = STATE_W'(ST_EXEC_R);
  localparam logic [STATE_W-1:0] S_ALU_WB    = STATE_W'(ST_ALU_WB);
  localparam logic [STATE_W-1:0] S_EXEC_I    = STATE_W'(ST_EXEC_I);
  localparam logic [STATE_W-1:0] S_TRAP      = STATE_W'(ST_TRAP);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_next;
  logic [3:0]         w_st_lo;
  logic               w_st_legal;
  logic               w_in_fetch;
  logic               w_ready;
  logic [6:0]         w_opcode7;
  ctrl_t              w_ctrl_dec;
  ctrl_t              w_ctrl_out;

  assign w_opcode7 = 7'(bus.opcode);
  assign w_st_lo   = r_state[3:0];

  generate
    if (STATE_W > 4) begin : g_hi_bits
      assign w_st_legal = ~|r_state[STATE_W-1:4];
    end else begin : g_no_hi_bits
      assign w_st_legal = 1'b1;
    end
  endgenerate

  assign w_in_fetch = w_st_legal && (w_st_lo == ST_FETCH);

`ifdef MC_CTRL_WAIT_EN
  assign w_ready = bus.mem_ready;
`else
  // Without the handshake every memory access completes in one cycle.
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign w_ready          = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic. mem_ready only matters in the three memory states.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = S_TRAP;
    if (w_st_legal) begin
      case (w_st_lo)
        ST_FETCH:     w_state_next = w_ready ? S_DECODE : S_FETCH;
        ST_DECODE:    w_state_next = STATE_W'(decode_opcode(w_opcode7));
        // Only loads and stores reach MEM_ADDR, and the opcode is stable.
        ST_MEM_ADDR:  w_state_next = (w_opcode7 == OP_LOAD) ? S_MEM_READ
                                                            : S_MEM_WRITE;
        ST_MEM_READ:  w_state_next = w_ready ? S_MEM_WB : S_MEM_READ;
        ST_MEM_WB:    w_state_next = S_FETCH;
        ST_MEM_WRITE: w_state_next = w_ready ? S_FETCH : S_MEM_WRITE;
        ST_EXEC_R:    w_state_next = S_ALU_WB;
        ST_ALU_WB:    w_state_next = S_FETCH;
        ST_BRANCH:    w_state_next = S_FETCH;
        ST_JAL:       w_state_next = S_FETCH;
        ST_EXEC_I:    w_state_next = S_ALU_WB;
        ST_TRAP:      w_state_next = S_TRAP;
        default:      w_state_next = S_TRAP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode and gating.
  // --------------------------------------------------------------------------
  mc_ctrl_out_dec #(
    .STATE_W (STATE_W)
  ) u_out_dec (
    .state (r_state),
    .ctrl  (w_ctrl_dec)
  );

  always_comb begin
    w_ctrl_out = w_ctrl_dec;
    // IR/PC must not latch until the instruction word is actually on the bus.
    if (w_in_fetch && !w_ready) begin
      w_ctrl_out.ir_write = 1'b0;
      w_ctrl_out.pc_write = 1'b0;
    end
    // Reset aborts the current instruction without any side effect.
    if (rst) begin
      w_ctrl_out = CTRL_IDLE;
    end
  end

  assign bus.pc_write      = w_ctrl_out.pc_write;
  assign bus.pc_write_cond = w_ctrl_out.pc_write_cond;
  assign bus.iord          = w_ctrl_out.iord;
  assign bus.mem_read      = w_ctrl_out.mem_read;
  assign bus.mem_write     = w_ctrl_out.mem_write;
  assign bus.ir_write      = w_ctrl_out.ir_write;
  assign bus.wb_sel        = w_ctrl_out.wb_sel;
  assign bus.pc_source     = w_ctrl_out.pc_source;
  assign bus.alu_op        = w_ctrl_out.alu_op;
  assign bus.alu_src_a     = w_ctrl_out.alu_src_a;
  assign bus.alu_src_b     = w_ctrl_out.alu_src_b;
  assign bus.reg_write     = w_ctrl_out.reg_write;
  assign bus.illegal_instr = w_ctrl_out.illegal_instr;
  assign bus.state         = rst ? '0 : r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl_fsm
// Description : Self-checking bench for multicycle_ctrl_fsm. A vector table
//               of {rst, opcode, mem_ready, expected state} rows drives the
//               DUT; expected outputs are queued when a row is driven and
//               popped at the following falling edge. A second sequence
//               measures per-instruction latency back to FETCH.
// Ports       : none (top-level bench)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

  logic clk;
  logic rst;

  multicycle_ctrl_fsm_if #(.OPCODE_W(7), .STATE_W(4)) bus_if ();

  multicycle_ctrl_fsm #(.OPCODE_W(7), .STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] wb_sel;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       illegal_instr;
  } cw_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       rdy;
    logic [3:0] st;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] st;
    cw_t        cw;
  } exp_t;

  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_R     = 7'b0110011;
  localparam logic [6:0] T_I     = 7'b0010011;
  localparam logic [6:0] T_BR    = 7'b1100011;
  localparam logic [6:0] T_JAL   = 7'b1101111;
  localparam logic [6:0] T_BAD   = 7'b1111111;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Control word each state must present, written from the state table.
  function automatic cw_t spec_cw(input logic [3:0] s, input logic rdy);
    cw_t c = '0;
    case (s)
      4'd0:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01;
                   c.ir_write = rdy; c.pc_write = rdy; end
      4'd1:  begin c.alu_src_b = 2'b11; end
      4'd2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd3:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      4'd4:  begin c.reg_write = 1'b1; c.wb_sel = 2'b01; end
      4'd5:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      4'd6:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b00; c.alu_op = 2'b10; end
      4'd7:  begin c.reg_write = 1'b1; c.wb_sel = 2'b00; end
      4'd8:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01;
                   c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
      4'd9:  begin c.pc_write = 1'b1; c.pc_source = 2'b01;
                   c.reg_write = 1'b1; c.wb_sel = 2'b10; end
      4'd10: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
      4'd11: begin c.illegal_instr = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic add(input logic r, input logic [6:0] o, input logic d,
                     input logic [3:0] s);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = d; v.st = s;
    vecs.push_back(v);
  endtask

  // Scoreboard consumer: compares one queued expectation per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      cw_t  got;
      e = exp_q.pop_front();
      got.pc_write      = bus_if.pc_write;
      got.pc_write_cond = bus_if.pc_write_cond;
      got.iord          = bus_if.iord;
      got.mem_read      = bus_if.mem_read;
      got.mem_write     = bus_if.mem_write;
      got.ir_write      = bus_if.ir_write;
      got.wb_sel        = bus_if.wb_sel;
      got.pc_source     = bus_if.pc_source;
      got.alu_op        = bus_if.alu_op;
      got.alu_src_a     = bus_if.alu_src_a;
      got.alu_src_b     = bus_if.alu_src_b;
      got.reg_write     = bus_if.reg_write;
      got.illegal_instr = bus_if.illegal_instr;
      checks++;
      if (bus_if.state !== e.st) begin
        errors++;
        $display("FAIL vec%0d state: got %0d expected %0d", e.idx, bus_if.state, e.st);
      end
      checks++;
      if (got !== e.cw) begin
        errors++;
        $display("FAIL vec%0d ctrl: got %05h expected %05h (state %0d)",
                 e.idx, got, e.cw, e.st);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic       eff_rdy;
    exp_t       e;
    logic [6:0] lat_op [6];
    int         lat_exp[6];
    int         cyc;

    rst              = 1'b1;
    bus_if.opcode    = '0;
    bus_if.mem_ready = 1'b1;

    // Reset held three cycles.
    add(1, 7'd0, 1, 0); add(1, 7'd0, 1, 0); add(1, 7'd0, 1, 0);
    // Load, zero wait: 0,1,2,3,4.
    add(0, T_LOAD, 1, 0); add(0, T_LOAD, 1, 1); add(0, T_LOAD, 1, 2);
    add(0, T_LOAD, 1, 3); add(0, T_LOAD, 1, 4);
    // Store with two wait cycles in MEM_WRITE.
    add(0, T_STORE, 1, 0); add(0, T_STORE, 1, 1); add(0, T_STORE, 1, 2);
`ifdef MC_CTRL_WAIT_EN
    add(0, T_STORE, 0, 5); add(0, T_STORE, 0, 5); add(0, T_STORE, 1, 5);
    // R-type with one fetch wait cycle.
    add(0, T_R, 0, 0); add(0, T_R, 1, 0);
`else
    // mem_ready low is ignored: MEM_WRITE and FETCH last one cycle.
    add(0, T_STORE, 0, 5);
    add(0, T_R, 0, 0);
`endif
    // mem_ready is ignored in DECODE.
    add(0, T_R, 0, 1); add(0, T_R, 1, 6); add(0, T_R, 1, 7);
    // I-type.
    add(0, T_I, 1, 0); add(0, T_I, 1, 1); add(0, T_I, 1, 10); add(0, T_I, 1, 7);
    // Branch and JAL.
    add(0, T_BR, 1, 0); add(0, T_BR, 1, 1); add(0, T_BR, 1, 8);
    add(0, T_JAL, 1, 0); add(0, T_JAL, 1, 1); add(0, T_JAL, 1, 9);
`ifdef MC_CTRL_WAIT_EN
    // Load with one wait cycle in MEM_READ.
    add(0, T_LOAD, 1, 0); add(0, T_LOAD, 1, 1); add(0, T_LOAD, 1, 2);
    add(0, T_LOAD, 0, 3); add(0, T_LOAD, 1, 3); add(0, T_LOAD, 1, 4);
`endif
    // Reset while MEM_READ is active aborts the load.
    add(0, T_LOAD, 1, 0); add(0, T_LOAD, 1, 1); add(0, T_LOAD, 1, 2);
    add(1, T_LOAD, 1, 0);
    // Illegal opcode traps and stays trapped.
    add(0, T_BAD, 1, 0); add(0, T_BAD, 1, 1);
    for (int i = 0; i < 11; i++) add(0, T_BAD, logic'(i % 2), 11);
    // Reset clears the trap and restarts at FETCH.
    add(1, T_BAD, 1, 0);
    add(0, T_R, 1, 0); add(0, T_R, 1, 1); add(0, T_R, 1, 6); add(0, T_R, 1, 7);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst              = vecs[i].rst;
      bus_if.opcode    = vecs[i].op;
      bus_if.mem_ready = vecs[i].rdy;
`ifdef MC_CTRL_WAIT_EN
      eff_rdy = vecs[i].rdy;
`else
      eff_rdy = 1'b1;
`endif
      e.idx = i;
      if (vecs[i].rst) begin
        e.st = 4'd0;
        e.cw = '0;
      end else begin
        e.st = vecs[i].st;
        e.cw = spec_cw(vecs[i].st, eff_rdy);
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end

    // Latency from FETCH entry back to FETCH with zero wait states.
    lat_op[0] = T_LOAD;  lat_exp[0] = 5;
    lat_op[1] = T_STORE; lat_exp[1] = 4;
    lat_op[2] = T_R;     lat_exp[2] = 4;
    lat_op[3] = T_I;     lat_exp[3] = 4;
    lat_op[4] = T_BR;    lat_exp[4] = 3;
    lat_op[5] = T_JAL;   lat_exp[5] = 3;
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      bus_if.opcode    = lat_op[k];
      bus_if.mem_ready = 1'b1;
      cyc = 0;
      do begin
        @(posedge clk);
        #1;
        cyc++;
      end while (bus_if.state != 4'd0 && cyc < 20);
      checks++;
      if (cyc != lat_exp[k]) begin
        errors++;
        $display("FAIL latency op=%07b: got %0d cycles expected %0d",
                 lat_op[k], cyc, lat_exp[k]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
